// File: rtl/keypad_pkg.sv
// Shared keypad types and defaults for the column debouncer.
package keypad_pkg;

  localparam int KEYPAD_COLS             = 4;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 10000;
  localparam int DEFAULT_SYNC_STAGES     = 2;

  typedef logic [KEYPAD_COLS-1:0] col_vec_t;

  // Bits needed for a counter that must reach `cycles` without wrapping.
  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/keypad_debouncer_sync_ff.sv
// Multi-flop synchroniser: brings an asynchronous vector into the clk domain.
module sync_ff #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_stage [STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign q = r_stage[STAGES-1];

endmodule

// File: rtl/keypad_debouncer.sv
// Whole-vector keypad column debouncer with input synchroniser.
// Optional KEYPAD_DEBOUNCER_PULSE_EN adds a one-cycle press_pulse on key_pressed rising.
module keypad_debouncer
  import keypad_pkg::*;
#(
  parameter int WIDTH           = KEYPAD_COLS,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sig_in,
  output logic [WIDTH-1:0] sig_out,
`ifdef KEYPAD_DEBOUNCER_PULSE_EN
  output logic             press_pulse,
`endif
  output logic             key_pressed
);

  localparam int                CNT_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] w_sync_q;
  logic [WIDTH-1:0] r_cand;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_sig_out;
  logic             r_key_pressed;

  sync_ff #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (sig_in),
    .q     (w_sync_q)
  );

  // Any change of the synchronised vector restarts the stability count;
  // once the count saturates the candidate is republished every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cand        <= '0;
      r_cnt         <= '0;
      r_sig_out     <= '0;
      r_key_pressed <= 1'b0;
    end else if (w_sync_q != r_cand) begin
      r_cand <= w_sync_q;
      r_cnt  <= '0;
    end else if (r_cnt == CNT_MAX) begin
      r_sig_out     <= r_cand;
      r_key_pressed <= |r_cand;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign sig_out     = r_sig_out;
  assign key_pressed = r_key_pressed;

`ifdef KEYPAD_DEBOUNCER_PULSE_EN
  logic r_press_pulse;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_press_pulse <= 1'b0;
    end else begin
      r_press_pulse <= (w_sync_q == r_cand) && (r_cnt == CNT_MAX)
                       && (|r_cand) && !r_key_pressed;
    end
  end

  assign press_pulse = r_press_pulse;
`endif

endmodule

// File: tb/tb_keypad_debouncer.sv
// Directed self-checking bench for keypad_debouncer (DEBOUNCE_CYCLES=4, SYNC_STAGES=2).
module tb_keypad_debouncer;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sig_in;
  logic [3:0] sig_out;
  logic       key_pressed;
`ifdef KEYPAD_DEBOUNCER_PULSE_EN
  logic       press_pulse;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  keypad_debouncer #(
    .WIDTH           (4),
    .DEBOUNCE_CYCLES (4),
    .SYNC_STAGES     (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sig_in      (sig_in),
    .sig_out     (sig_out),
`ifdef KEYPAD_DEBOUNCER_PULSE_EN
    .press_pulse (press_pulse),
`endif
    .key_pressed (key_pressed)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    sig_in = 4'b1111;
    reset  = 1'b1;
    tick();
    tick();
    n_checks++;
    if (sig_out !== 4'b0000 || key_pressed !== 1'b0)
      $display("FAIL reset_state sig_out=%b kp=%b expected 0000/0", sig_out, key_pressed);
    else n_pass++;
    reset = 1'b0;
    repeat (6) tick();
    n_checks++;
    if (sig_out !== 4'b0000 || key_pressed !== 1'b0)
      $display("FAIL reset_early sig_out=%b kp=%b expected 0000/0", sig_out, key_pressed);
    else n_pass++;
    tick();
    n_checks++;
    if (sig_out !== 4'b1111 || key_pressed !== 1'b1)
      $display("FAIL reset_release sig_out=%b kp=%b expected 1111/1", sig_out, key_pressed);
    else n_pass++;
    $display("reset: sig_out=%b key_pressed=%b", sig_out, key_pressed);
  endtask

  task automatic test_sequence();
    logic [3:0] vals [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [3:0] prev = 4'b1111;
    for (int v = 0; v < 4; v++) begin
      sig_in = vals[v];
      repeat (6) tick();
      n_checks++;
      if (sig_out !== prev || key_pressed !== 1'b1)
        $display("FAIL seq_early[%0d] sig_out=%b kp=%b expected %b/1", v, sig_out, key_pressed, prev);
      else n_pass++;
      tick();
      n_checks++;
      if (sig_out !== vals[v] || key_pressed !== 1'b1)
        $display("FAIL seq_update[%0d] sig_out=%b kp=%b expected %b/1", v, sig_out, key_pressed, vals[v]);
      else n_pass++;
      for (int c = 0; c < 13; c++) begin
        tick();
        n_checks++;
        if (sig_out !== vals[v] || key_pressed !== 1'b1)
          $display("FAIL seq_hold[%0d] cyc=%0d sig_out=%b kp=%b expected %b/1", v, c, sig_out, key_pressed, vals[v]);
        else n_pass++;
      end
      $display("sequence: sig_in=%b sig_out=%b key_pressed=%b", sig_in, sig_out, key_pressed);
      prev = vals[v];
    end
  endtask

  task automatic test_glitch();
    sig_in = 4'b0000;
    repeat (7) tick();
    n_checks++;
    if (sig_out !== 4'b0000 || key_pressed !== 1'b0)
      $display("FAIL glitch_release sig_out=%b kp=%b expected 0000/0", sig_out, key_pressed);
    else n_pass++;
    sig_in = 4'b0100;
    tick();
    tick();
    sig_in = 4'b0000;
    for (int c = 0; c < 12; c++) begin
      tick();
      n_checks++;
      if (sig_out !== 4'b0000 || key_pressed !== 1'b0)
        $display("FAIL glitch_hold cyc=%0d sig_out=%b kp=%b expected 0000/0", c, sig_out, key_pressed);
      else n_pass++;
    end
    $display("glitch: 2-cycle 0100 pulse, sig_out=%b key_pressed=%b", sig_out, key_pressed);
  endtask

  task automatic test_bounce();
    logic [3:0] pat [5] = '{4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0010};
    for (int p = 0; p < 4; p++) begin
      sig_in = pat[p];
      tick();
      n_checks++;
      if (sig_out !== 4'b0000)
        $display("FAIL bounce_phase[%0d] sig_out=%b expected 0000", p, sig_out);
      else n_pass++;
    end
    sig_in = pat[4];
    for (int c = 0; c < 6; c++) begin
      tick();
      n_checks++;
      if (sig_out !== 4'b0000 || key_pressed !== 1'b0)
        $display("FAIL bounce_early cyc=%0d sig_out=%b kp=%b expected 0000/0", c, sig_out, key_pressed);
      else n_pass++;
    end
    tick();
    n_checks++;
    if (sig_out !== 4'b0010 || key_pressed !== 1'b1)
      $display("FAIL bounce_settle sig_out=%b kp=%b expected 0010/1", sig_out, key_pressed);
    else n_pass++;
    repeat (3) tick();
    n_checks++;
    if (sig_out !== 4'b0010)
      $display("FAIL bounce_hold sig_out=%b expected 0010", sig_out);
    else n_pass++;
    $display("bounce: sig_out=%b key_pressed=%b", sig_out, key_pressed);
  endtask

  task automatic test_release_reset();
    sig_in = 4'b1000;
    repeat (7) tick();
    n_checks++;
    if (sig_out !== 4'b1000)
      $display("FAIL release_setup sig_out=%b expected 1000", sig_out);
    else n_pass++;
    sig_in = 4'b0000;
    repeat (6) tick();
    n_checks++;
    if (sig_out !== 4'b1000 || key_pressed !== 1'b1)
      $display("FAIL release_early sig_out=%b kp=%b expected 1000/1", sig_out, key_pressed);
    else n_pass++;
    tick();
    n_checks++;
    if (sig_out !== 4'b0000 || key_pressed !== 1'b0)
      $display("FAIL release_done sig_out=%b kp=%b expected 0000/0", sig_out, key_pressed);
    else n_pass++;
    $display("release: sig_out=%b key_pressed=%b", sig_out, key_pressed);
    // 0001 reaches the synchroniser, then three counting cycles elapse before reset.
    sig_in = 4'b0001;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    n_checks++;
    if (sig_out !== 4'b0000 || key_pressed !== 1'b0)
      $display("FAIL midcount_reset sig_out=%b kp=%b expected 0000/0", sig_out, key_pressed);
    else n_pass++;
    reset = 1'b0;
    repeat (6) tick();
    n_checks++;
    if (sig_out !== 4'b0000)
      $display("FAIL midcount_restart_early sig_out=%b expected 0000", sig_out);
    else n_pass++;
    tick();
    n_checks++;
    if (sig_out !== 4'b0001 || key_pressed !== 1'b1)
      $display("FAIL midcount_restart sig_out=%b kp=%b expected 0001/1", sig_out, key_pressed);
    else n_pass++;
    $display("midcount reset: sig_out=%b key_pressed=%b", sig_out, key_pressed);
  endtask

`ifdef KEYPAD_DEBOUNCER_PULSE_EN
  task automatic test_pulse();
    sig_in = 4'b0000;
    repeat (8) tick();
    sig_in = 4'b0001;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_checks++;
      if (press_pulse !== 1'b0 || key_pressed !== 1'b0)
        $display("FAIL pulse_early cyc=%0d pulse=%b kp=%b expected 0/0", c, press_pulse, key_pressed);
      else n_pass++;
    end
    tick();
    n_checks++;
    if (press_pulse !== 1'b1 || key_pressed !== 1'b1)
      $display("FAIL pulse_rise pulse=%b kp=%b expected 1/1", press_pulse, key_pressed);
    else n_pass++;
    tick();
    n_checks++;
    if (press_pulse !== 1'b0 || key_pressed !== 1'b1)
      $display("FAIL pulse_width pulse=%b kp=%b expected 0/1", press_pulse, key_pressed);
    else n_pass++;
    sig_in = 4'b0010;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks++;
      if (press_pulse !== 1'b0)
        $display("FAIL pulse_change cyc=%0d pulse=%b expected 0", c, press_pulse);
      else n_pass++;
    end
    $display("pulse: sig_out=%b press_pulse=%b", sig_out, press_pulse);
  endtask
`endif

  initial begin
    reset  = 1'b0;
    sig_in = 4'b0000;
    test_reset();
    test_sequence();
    test_glitch();
    test_bounce();
    test_release_reset();
`ifdef KEYPAD_DEBOUNCER_PULSE_EN
    test_pulse();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
